// File: rtl/v1_peak_detector.sv
// Peak detector for a shaped (trapezoidal-filtered) pulse stream.
// Registers each input sample with a timestamp, tracks the maximum of every
// over-threshold run, emits (amplitude, time, width) for runs that are long
// enough, then blanks the input for a programmable dead time. Events are
// offered on a valid/ready port; events that arrive while the previous one is
// still pending are dropped and counted.
module v1_peak_detector #(
  parameter int DATA_W    = 16,
  parameter int TS_W      = 32,
  parameter int DEAD_TIME = 8,
  parameter int MIN_WIDTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] filter_data,
  input  logic signed [DATA_W-1:0] threshold,
  input  logic                     enable,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_amp,
  output logic [TS_W-1:0]          out_time,
  output logic [7:0]               out_width,
  output logic [15:0]              lost_cnt,
  output logic                     busy
);

  // Dead-time counter wide enough to hold DEAD_TIME (at least one bit).
  localparam int DC_W = (DEAD_TIME < 1) ? 1 : $clog2(DEAD_TIME + 1);
  localparam logic [DC_W-1:0] DEAD_LOAD = DC_W'(DEAD_TIME);
  localparam logic [7:0]      MIN_W8    = 8'(MIN_WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DEAD  = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [TS_W-1:0]           ts_q;
  logic signed [DATA_W-1:0]  sample_q;
  logic [TS_W-1:0]           sample_ts_q;
  logic signed [DATA_W-1:0]  max_q, max_d;
  logic [TS_W-1:0]           max_ts_q, max_ts_d;
  logic [7:0]                width_q, width_d;
  logic [DC_W-1:0]           dead_cnt_q, dead_cnt_d;
  logic                      out_valid_q, out_valid_d;
  logic signed [DATA_W-1:0]  out_amp_q, out_amp_d;
  logic [TS_W-1:0]           out_time_q, out_time_d;
  logic [7:0]                out_width_q, out_width_d;
  logic [15:0]               lost_q, lost_d;
  logic                      above;
  logic                      emit;

  // Input register: sample plus the free-running timestamp at that edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts_q        <= '0;
      sample_q    <= '0;
      sample_ts_q <= '0;
    end else begin
      ts_q        <= ts_q + TS_W'(1);
      sample_q    <= filter_data;
      sample_ts_q <= ts_q;
    end
  end

  // Next-state logic for the pulse FSM and the event output holding register.
  always_comb begin
    state_d     = state_q;
    max_d       = max_q;
    max_ts_d    = max_ts_q;
    width_d     = width_q;
    dead_cnt_d  = dead_cnt_q;
    out_valid_d = out_valid_q;
    out_amp_d   = out_amp_q;
    out_time_d  = out_time_q;
    out_width_d = out_width_q;
    lost_d      = lost_q;
    emit        = 1'b0;
    above       = (sample_q > threshold);

    case (state_q)
      IDLE: begin
        if (enable && above) begin
          state_d  = ARMED;
          max_d    = sample_q;
          max_ts_d = sample_ts_q;
          width_d  = 8'd1;
        end
      end
      ARMED: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (above) begin
          if (width_q != 8'hFF) width_d = width_q + 8'd1;
          // Strict compare: on a tie the earliest maximum is kept.
          if (sample_q > max_q) begin
            max_d    = sample_q;
            max_ts_d = sample_ts_q;
          end
        end else if (width_q >= MIN_W8) begin
          emit       = 1'b1;
          state_d    = DEAD;
          dead_cnt_d = DEAD_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      DEAD: begin
        // A load of 0 or 1 both leave DEAD after a single cycle.
        if (dead_cnt_q <= DC_W'(1)) state_d = IDLE;
        else                        dead_cnt_d = dead_cnt_q - DC_W'(1);
      end
      default: state_d = IDLE;
    endcase

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    if (emit) begin
      if (!out_valid_q || out_ready) begin
        out_valid_d = 1'b1;
        out_amp_d   = max_q;
        out_time_d  = max_ts_q;
        out_width_d = width_q;
      end else if (lost_q != 16'hFFFF) begin
        lost_d = lost_q + 16'd1;
      end
    end
  end

  // State and event registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      max_q       <= '0;
      max_ts_q    <= '0;
      width_q     <= '0;
      dead_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_amp_q   <= '0;
      out_time_q  <= '0;
      out_width_q <= '0;
      lost_q      <= '0;
    end else begin
      state_q     <= state_d;
      max_q       <= max_d;
      max_ts_q    <= max_ts_d;
      width_q     <= width_d;
      dead_cnt_q  <= dead_cnt_d;
      out_valid_q <= out_valid_d;
      out_amp_q   <= out_amp_d;
      out_time_q  <= out_time_d;
      out_width_q <= out_width_d;
      lost_q      <= lost_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_amp   = out_amp_q;
  assign out_time  = out_time_q;
  assign out_width = out_width_q;
  assign lost_cnt  = lost_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_v1_peak_detector.sv
// Directed bench for v1_peak_detector with an expected-event scoreboard.
module tb_v1_peak_detector;

  logic               clk = 1'b0;
  logic               reset;
  logic signed [15:0] filter_data;
  logic signed [15:0] threshold;
  logic               enable;
  logic               out_ready;
  logic               out_valid;
  logic signed [15:0] out_amp;
  logic [3:0]         out_time;
  logic [7:0]         out_width;
  logic [15:0]        lost_cnt;
  logic               busy;

  v1_peak_detector #(
    .DATA_W(16), .TS_W(4), .DEAD_TIME(8), .MIN_WIDTH(2)
  ) dut (
    .clk(clk), .reset(reset), .filter_data(filter_data), .threshold(threshold),
    .enable(enable), .out_ready(out_ready), .out_valid(out_valid),
    .out_amp(out_amp), .out_time(out_time), .out_width(out_width),
    .lost_cnt(lost_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int amp;
    int tm;
    int wd;
  } ev_t;

  ev_t sb[$];
  int  compared   = 0;
  int  mismatched = 0;
  int  cyc        = 0;
  int  last_tag   = 0;
  int  handshakes = 0;

  task automatic chk(input string tag, input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present one sample; a handshake that the coming edge will perform is
  // popped from the scoreboard and compared first.
  task automatic drive(input int v);
    ev_t e;
    filter_data = 16'(v);
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      handshakes++;
      compared++;
      assert (sb.size() != 0) else begin
        mismatched++;
        $error("FAIL unexpected_event: observed amp %0d time %0d, expected none",
               out_amp, out_time);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("ev_amp",   32'(out_amp),   e.amp);
        chk("ev_time",  32'(out_time),  e.tm);
        chk("ev_width", 32'(out_width), e.wd);
      end
    end
    @(posedge clk);
    last_tag = cyc & 15;
    cyc++;
    #1;
  endtask

  task automatic zeros(input int n);
    for (int i = 0; i < n; i++) drive(0);
  endtask

  task automatic check_reset_state();
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_amp",   32'(out_amp),   0);
    chk("rst_time",  32'(out_time),  0);
    chk("rst_width", 32'(out_width), 0);
    chk("rst_lost",  32'(lost_cnt),  0);
    chk("rst_busy",  32'(busy),      0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    check_reset_state();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc   = 0;
  endtask

  initial begin
    int t;
    int t2;
    reset       = 1'b1;
    filter_data = '0;
    threshold   = 16'sd100;
    enable      = 1'b1;
    out_ready   = 1'b1;
    @(posedge clk);
    #1;
    do_reset();

    // Single pulse with exact output latency and dead-time length.
    drive(0); drive(150); drive(300); t = last_tag; drive(250);
    drive(50);
    sb.push_back('{amp: 300, tm: t, wd: 3});
    chk("lat_edge1_valid", 32'(out_valid), 0);
    drive(0);
    chk("lat_edge2_valid", 32'(out_valid), 1);
    chk("dead_busy_start", 32'(busy), 1);
    zeros(7);
    chk("dead_busy_last", 32'(busy), 1);
    drive(0);
    chk("dead_busy_done", 32'(busy), 0);
    zeros(2);

    // Glitch shorter than the minimum width.
    drive(500); drive(0); zeros(3);
    chk("glitch_valid", 32'(out_valid), 0);
    chk("glitch_busy",  32'(busy), 0);
    chk("glitch_lost",  32'(lost_cnt), 0);

    // Tie keeps the first maximum.
    drive(200); t = last_tag; drive(200); drive(0);
    sb.push_back('{amp: 200, tm: t, wd: 2});
    zeros(12);

    // Dead time: pulse 3 cycles after the end is ignored, 10 after is seen.
    drive(150); drive(300); t = last_tag; drive(50);
    sb.push_back('{amp: 300, tm: t, wd: 2});
    zeros(2);
    drive(400); drive(400);
    zeros(4);
    chk("dead2_busy_last", 32'(busy), 1);
    drive(0);
    chk("dead2_busy_done", 32'(busy), 0);
    drive(120); drive(130); t2 = last_tag; drive(0);
    sb.push_back('{amp: 130, tm: t2, wd: 2});
    zeros(12);

    // Enable drop while armed aborts silently.
    drive(150); drive(160); enable = 1'b0; drive(150); drive(0);
    enable = 1'b1;
    zeros(3);
    chk("abort_valid", 32'(out_valid), 0);

    // Backpressure: second event lost, third loaded on the accepting edge.
    out_ready = 1'b0;
    drive(150); drive(250); t = last_tag; drive(0);
    sb.push_back('{amp: 250, tm: t, wd: 2});
    zeros(12);
    drive(180); drive(170); drive(0);
    zeros(12);
    chk("bp_lost",       32'(lost_cnt), 1);
    chk("bp_held_valid", 32'(out_valid), 1);
    chk("bp_held_amp",   32'(out_amp), 250);
    drive(150); drive(260); t = last_tag; drive(0);
    sb.push_back('{amp: 260, tm: t, wd: 2});
    out_ready = 1'b1;
    drive(0);
    chk("bp_swap_valid", 32'(out_valid), 1);
    chk("bp_swap_lost",  32'(lost_cnt), 1);
    zeros(12);
    chk("bp_drained", 32'(out_valid), 0);

    // Reset while armed abandons the pulse.
    drive(150); drive(200); drive(220);
    chk("armed_busy", 32'(busy), 1);
    do_reset();
    zeros(4);
    chk("post_rst_valid", 32'(out_valid), 0);
    chk("post_rst_busy",  32'(busy), 0);

    // Timestamp wrap 15 -> 0 under a pulse whose peak lands on tag 0.
    while ((cyc & 15) != 14) drive(0);
    drive(150); drive(200); drive(300); t = last_tag; drive(0);
    sb.push_back('{amp: 300, tm: t, wd: 3});
    zeros(12);

    chk("sb_empty",   sb.size(), 0);
    chk("handshakes", handshakes, 7);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
